// File: rtl/mm_pkg.sv
// Shared types for the Mastermind codebreaker: code/score encodings, history entries
// and the solver state encoding.
package mm_pkg;

  localparam int NUM_PEGS   = 4;
  localparam int NUM_COLORS = 4;

  typedef logic [1:0] digit_t;
  typedef logic [7:0] code_t;   // digit3 = [7:6] .. digit0 = [1:0]

  typedef struct packed {
    logic [2:0] exact;
    logic [2:0] partial;
  } score_t;

  typedef struct packed {
    code_t  code;
    score_t score;
  } hist_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESENT,
    S_CHECK,
    S_SEARCH,
    S_DONE,
    S_FAIL
  } state_t;

endpackage

// File: rtl/mastermind_solver_if.sv
// Game-side bus of the codebreaker: start/feedback in, guess and status out.
interface mastermind_solver_if;
  import mm_pkg::*;

  logic       start;
  logic       fb_valid;
  logic [2:0] fb_exact;
  logic [2:0] fb_partial;
  code_t      guess;
  logic       guess_valid;
  logic       busy;
  logic       solved;
  logic       fail;
  logic [3:0] guess_count;

  modport slave (
    input  start, fb_valid, fb_exact, fb_partial,
    output guess, guess_valid, busy, solved, fail, guess_count
  );

  modport master (
    output start, fb_valid, fb_exact, fb_partial,
    input  guess, guess_valid, busy, solved, fail, guess_count
  );

endinterface

// File: rtl/mm_score.sv
// Combinational Mastermind scorer: exact matches plus colour-overlap partials.
module mm_score
  import mm_pkg::*;
(
  input  code_t  a_i,
  input  code_t  b_i,
  output score_t score_o
);

  logic [2:0] ex, tot, na, nb;

  // NOTE: blocking assignments here are intentional; the accumulators are
  // read back within the same pass, and each gets a default up front so no latch forms.
  always_comb begin
    ex  = '0;
    tot = '0;
    na  = '0;
    nb  = '0;
    for (int p = 0; p < NUM_PEGS; p++) begin
      if (a_i[2*p +: 2] == b_i[2*p +: 2]) ex = ex + 3'd1;
    end
    for (int c = 0; c < NUM_COLORS; c++) begin
      na = '0;
      nb = '0;
      for (int p = 0; p < NUM_PEGS; p++) begin
        if (a_i[2*p +: 2] == digit_t'(c)) na = na + 3'd1;
        if (b_i[2*p +: 2] == digit_t'(c)) nb = nb + 3'd1;
      end
      tot = tot + ((na < nb) ? na : nb);
    end
    score_o = '{exact: ex, partial: tot - ex};
  end

endmodule

// File: rtl/mastermind_solver.sv
// Mastermind codebreaker: proposes guesses and scans the code space for one consistent
// with all feedback. Define MM_SOLVER_FB_CHECK_EN to reject impossible feedback immediately.
module mastermind_solver
  import mm_pkg::*;
#(
  parameter int    MAX_GUESSES = 8,
  parameter code_t FIRST_GUESS = 8'h05
) (
  input logic          clk,
  input logic          reset,
  mastermind_solver_if.slave bus
);

  localparam int HIW = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1;
  localparam int HCW = $clog2(MAX_GUESSES + 1);

  state_t           state_q;
  code_t            guess_q, cand_q;
  logic             guess_valid_q, busy_q, solved_q, fail_q;
  logic [3:0]       guess_count_q;
  logic [HCW-1:0]   hcount_q;
  logic [HIW-1:0]   hidx_q;
  hist_t            hist_q [MAX_GUESSES];

  hist_t  cur_h;
  score_t cand_s, fb_s;
  logic   cand_match, last_idx, fb_last;

  assign cur_h      = hist_q[hidx_q];
  assign fb_s       = '{exact: bus.fb_exact, partial: bus.fb_partial};
  assign cand_match = (cand_s == cur_h.score);
  assign last_idx   = (HCW'(hidx_q) == hcount_q - HCW'(1));
  assign fb_last    = (hcount_q == HCW'(MAX_GUESSES - 1));

`ifdef MM_SOLVER_FB_CHECK_EN
  logic fb_bad;
  assign fb_bad = (({1'b0, bus.fb_exact} + {1'b0, bus.fb_partial}) > 4'd4) ||
                  (bus.fb_exact == 3'd3 && bus.fb_partial == 3'd1);
`endif

  mm_score u_score (
    .a_i    (cand_q),
    .b_i    (cur_h.code),
    .score_o(cand_s)
  );

  // Status outputs are decided when feedback is accepted, so solved/fail are visible during CHECK.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: hist_q is deliberately not reset; hcount_q alone defines which entries are valid.
      state_q       <= S_IDLE;
      guess_q       <= '0;
      cand_q        <= '0;
      guess_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      solved_q      <= 1'b0;
      fail_q        <= 1'b0;
      guess_count_q <= '0;
      hcount_q      <= '0;
      hidx_q        <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (bus.start) begin
            state_q       <= S_PRESENT;
            guess_q       <= FIRST_GUESS;
            guess_count_q <= 4'd1;
            guess_valid_q <= 1'b1;
            busy_q        <= 1'b1;
            solved_q      <= 1'b0;
            fail_q        <= 1'b0;
            hcount_q      <= '0;
          end
        end
        S_PRESENT: begin
          if (bus.fb_valid) begin
            guess_valid_q <= 1'b0;
`ifdef MM_SOLVER_FB_CHECK_EN
            if (fb_bad) begin
              state_q <= S_FAIL;
              fail_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else
`endif
            begin
              hist_q[hcount_q[HIW-1:0]] <= '{code: guess_q, score: fb_s};
              hcount_q <= hcount_q + HCW'(1);
              state_q  <= S_CHECK;
              if (fb_s.exact == 3'd4) begin
                solved_q <= 1'b1;
                busy_q   <= 1'b0;
              end else if (fb_last) begin
                fail_q <= 1'b1;
                busy_q <= 1'b0;
              end
            end
          end
        end
        S_CHECK: begin
          hidx_q <= '0;
          cand_q <= (hcount_q == HCW'(1)) ? 8'h00 : guess_q + 8'h01;
          if (solved_q)    state_q <= S_DONE;
          else if (fail_q) state_q <= S_FAIL;
          else             state_q <= S_SEARCH;
        end
        S_SEARCH: begin
          if (!cand_match) begin
            if (cand_q == 8'hFF) begin
              state_q <= S_FAIL;
              fail_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              cand_q <= cand_q + 8'h01;
              hidx_q <= '0;
            end
          end else if (last_idx) begin
            guess_q       <= cand_q;
            guess_count_q <= guess_count_q + 4'd1;
            guess_valid_q <= 1'b1;
            state_q       <= S_PRESENT;
          end else begin
            hidx_q <= hidx_q + HIW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.guess       = guess_q;
  assign bus.guess_valid = guess_valid_q;
  assign bus.busy        = busy_q;
  assign bus.solved      = solved_q;
  assign bus.fail        = fail_q;
  assign bus.guess_count = guess_count_q;

endmodule

// File: doc/mastermind_solver.md
# mastermind_solver

Automatic codebreaker for the Mastermind game, the counterpart of the human-guesses-machine-code flow. The human holds a secret code and scores each machine guess. The block proposes guesses, accepts exact/partial feedback, and searches the 256-entry code space for the next guess consistent with all feedback so far. It sits beside the LFSR/comparator path and drives the HEX/LEDR display logic with its guess and status.

## Interface
Parameters:
- MAX_GUESSES, 8: history depth; the game is lost after this many non-winning guesses.
- FIRST_GUESS, 8'h05: opening guess, digits {0,0,1,1}.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a game
- fb_valid  in  1  one-cycle pulse; feedback for the current guess is present
- fb_exact  in  3  right colour, right position (0..4)
- fb_partial  in  3  right colour, wrong position (0..4)
- guess  out  8  current guess; four 2-bit digits, digit3 = [7:6] .. digit0 = [1:0]
- guess_valid  out  1  guess is presented and awaiting feedback
- busy  out  1  game in progress (any state except IDLE/DONE/FAIL)
- solved  out  1  last feedback was exact=4
- fail  out  1  no consistent candidate, guesses exhausted, or invalid feedback
- guess_count  out  4  number of guesses presented this game

## Operation
- Score(a,b): exact = count of equal digit positions; partial = Σ over colours 0..3 of min(count_a, count_b) − exact.
- History: up to MAX_GUESSES entries of {guess, exact, partial}; hcount entries valid.
- States:
  - IDLE: start → PRESENT with guess=FIRST_GUESS, guess_count=1; history cleared.
  - PRESENT: guess_valid=1. fb_valid → store the entry, go to CHECK. fb_valid outside PRESENT is ignored.
  - CHECK:
    - exact=4 → DONE (solved=1).
    - Otherwise, hcount==MAX_GUESSES → FAIL.
    - Otherwise → SEARCH, with cand = 0 after the first guess, else last guess+1.
  - SEARCH: one (cand, hist[hidx]) evaluation per cycle.
    - Mismatch: cand++, hidx=0.
    - Match and hidx==hcount−1: guess<=cand, guess_count++, → PRESENT.
    - Match otherwise: hidx++.
    - Mismatch at cand==255 → FAIL.
  - DONE / FAIL: outputs hold. start → restart as from IDLE.
- start is ignored in PRESENT, CHECK and SEARCH.
- Reset in any state → IDLE. Reset values: guess=0, guess_valid=0, busy=0, solved=0, fail=0, guess_count=0. History is cleared.

## Timing
- start at edge t → guess_valid=1, guess=FIRST_GUESS visible after edge t+1.
- fb_valid sampled at edge t → CHECK during t+1 → SEARCH from t+2.
- Next guess_valid appears 2 + E cycles after fb_valid, where E = number of evaluations performed.
- solved or fail asserts one cycle after the deciding fb_valid (CHECK), or on the failing SEARCH cycle.
- guess and guess_count change only on entry to PRESENT.

## Configuration
- MM_SOLVER_FB_CHECK_EN defined:
  - In PRESENT, feedback with exact+partial>4, or exact==3 && partial==1, → FAIL on the next cycle.
  - The invalid entry is not stored.
- MM_SOLVER_FB_CHECK_EN undefined: all feedback is stored. Contradictory feedback ends in FAIL through search exhaustion.

## Structure
- Package mm_pkg: NUM_PEGS=4, NUM_COLORS=4, digit_t (2 bits), code_t (8 bits), score_t struct {exact, partial} (3 bits each), hist_t struct {code_t, score_t}, solver state enum.
- Sub-module mm_score: combinational Score(a,b) → score_t. SEARCH uses one instance; the bench reuses it as the reference scorer.

## Test plan
- Reset, then start → guess=8'h05, guess_valid=1, guess_count=1 one cycle after start; busy=1.
- Feedback (4,0) on 8'h05 → solved=1, busy=0, guess_valid=0 one cycle later; guess_count stays 1.
- Feedback (0,0) on 8'h05 → next guess=8'hAA, guess_valid asserted 173 cycles after fb_valid (2 + 171 evaluations).
- Closed loop, bench scores with mm_score against secret 8'hE4 (first feedback (1,1)) → solved within 8 guesses; every guess is consistent with all prior feedback.
- Feedback (3,1) with MM_SOLVER_FB_CHECK_EN → fail=1 next cycle. Without the macro → entry stored and the game eventually ends in fail=1.
- Reset asserted mid-SEARCH → all outputs 0 next cycle. fb_valid pulsed in IDLE → ignored. start pulsed in SEARCH → ignored.
